// File: rtl/wave_pkg.sv
// Shared definitions for the waveform generator / monitor pair: widths, monitor
// state encoding and the waveform selection codes.
package wave_pkg;

    localparam int WAVE_W_DEFAULT = 5;
    localparam int CNT_W_DEFAULT  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        CLK    = 2'd3
    } wave_choise_t;

endpackage

// File: rtl/wave_result_holder.sv
// Single-entry valid/ready result register; a result loads on the edge it arrives.
// When full and not accepted, a newly arriving result is dropped and overflow sticks.
module wave_result_holder #(
    parameter int DAT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             new_vld,
    input  logic [DAT_W-1:0] new_dat,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [DAT_W-1:0] res_dat,
    output logic             overflow
);

    logic load;

    // Accepting the held entry in the same cycle frees the slot for the new one.
    assign load = new_vld && (!res_valid || res_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_dat   <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            res_valid <= 1'b0;
            res_dat   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                res_dat   <= new_dat;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (new_vld && !load) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_monitor.sv
// Measures period, peak and trough between rising threshold crossings of a sample stream;
// result registered on the ending crossing edge, held in a one-entry drop-on-full holder.
module wave_monitor
    import wave_pkg::*;
#(
    parameter int          WAVE_W = wave_pkg::WAVE_W_DEFAULT,
    parameter int          CNT_W  = wave_pkg::CNT_W_DEFAULT,
    parameter int unsigned THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [WAVE_W-1:0] wave_in,
    input  logic              wave_vld,
    output logic [CNT_W-1:0]  res_period,
    output logic [WAVE_W-1:0] res_max,
    output logic [WAVE_W-1:0] res_min,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              overflow,
    output logic              timeout
);

    localparam logic [WAVE_W-1:0] THR     = WAVE_W'(THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam int                RES_W   = CNT_W + 2 * WAVE_W;

    mon_state_t        state_q, state_d;
    logic [WAVE_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAVE_W-1:0] run_max_q, run_max_d;
    logic [WAVE_W-1:0] run_min_q, run_min_d;
    logic              timeout_d;
    logic              emit;
    logic              crossing;
    logic [RES_W-1:0]  res_dat;

    assign crossing = wave_vld && (prev_q < THR) && (wave_in >= THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (wave_vld) begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (crossing) state_d = MEASURE;
                MEASURE: if (!crossing && cnt_q == CNT_MAX) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values; a crossing in MEASURE closes one period and opens the next.
    always_comb begin
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        timeout_d = 1'b0;
        emit      = 1'b0;
        if (wave_vld) begin
            prev_d = wave_in;
            case (state_q)
                ARM: begin
                    if (crossing) begin
                        cnt_d     = CNT_W'(1);
                        run_max_d = wave_in;
                        run_min_d = wave_in;
                    end
                end
                MEASURE: begin
                    if (crossing) begin
                        emit      = 1'b1;
                        cnt_d     = CNT_W'(1);
                        run_max_d = wave_in;
                        run_min_d = wave_in;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (wave_in > run_max_q) run_max_d = wave_in;
                        if (wave_in < run_min_q) run_min_d = wave_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            run_max_q <= '0;
            run_min_q <= '1;
            timeout   <= 1'b0;
        end else if (clr) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            run_max_q <= '0;
            run_min_q <= '1;
            timeout   <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            timeout   <= timeout_d;
        end
    end

    wave_result_holder #(
        .DAT_W (RES_W)
    ) u_holder (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .new_vld   (emit),
        .new_dat   ({cnt_q, run_max_q, run_min_q}),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_dat   (res_dat),
        .overflow  (overflow)
    );

    assign res_period = res_dat[RES_W-1 -: CNT_W];
    assign res_max    = res_dat[2*WAVE_W-1 -: WAVE_W];
    assign res_min    = res_dat[WAVE_W-1:0];

endmodule

// File: tb/tb_wave_monitor.sv
// Directed and random stimulus for wave_monitor, checked every cycle against a
// sample-queue reference model of periods, extremes and the one-entry holder.
module tb_wave_monitor;

    localparam int THR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [4:0] wave_in = '0;
    logic       wave_vld = 1'b0;
    logic       res_ready = 1'b0;
    logic [7:0] res_period;
    logic [4:0] res_max;
    logic [4:0] res_min;
    logic       res_valid;
    logic       overflow;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_seen;
    bit         m_meas;
    logic [4:0] m_prev;
    logic [4:0] q[$];
    bit         m_tmo;
    bit         h_vld;
    int         h_per;
    int         h_max;
    int         h_min;
    bit         h_ovf;

    wave_monitor #(
        .WAVE_W (5),
        .CNT_W  (8),
        .THRESH (THR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .wave_in    (wave_in),
        .wave_vld   (wave_vld),
        .res_period (res_period),
        .res_max    (res_max),
        .res_min    (res_min),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_meas = 0; m_prev = '0; q.delete();
        m_tmo = 0; h_vld = 0; h_per = 0; h_max = 0; h_min = 0; h_ovf = 0;
    endtask

    task automatic model_step(input bit v, input logic [4:0] s, input bit r, input bit c);
        bit emit;
        int e_per, e_max, e_min;
        emit = 0; e_per = 0; e_max = 0; e_min = 31;
        m_tmo = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (v) begin
            if (m_seen && int'(m_prev) < THR && int'(s) >= THR) begin
                if (m_meas) begin
                    emit  = 1;
                    e_per = q.size();
                    foreach (q[i]) begin
                        if (int'(q[i]) > e_max) e_max = int'(q[i]);
                        if (int'(q[i]) < e_min) e_min = int'(q[i]);
                    end
                end
                q.delete();
                q.push_back(s);
                m_meas = 1;
            end else if (m_meas) begin
                if (q.size() == 255) begin
                    m_tmo  = 1;
                    m_meas = 0;
                    q.delete();
                end else begin
                    q.push_back(s);
                end
            end
            m_seen = 1;
            m_prev = s;
        end
        if (emit) begin
            if (!h_vld || r) begin
                h_vld = 1; h_per = e_per; h_max = e_max; h_min = e_min;
            end else begin
                h_ovf = 1;
            end
        end else if (h_vld && r) begin
            h_vld = 0;
        end
    endtask

    task automatic compare();
        chk("res_valid", int'(res_valid), int'(h_vld));
        if (h_vld) begin
            chk("res_period", int'(res_period), h_per);
            chk("res_max", int'(res_max), h_max);
            chk("res_min", int'(res_min), h_min);
        end
        chk("overflow", int'(overflow), int'(h_ovf));
        chk("timeout", int'(timeout), int'(m_tmo));
    endtask

    task automatic step(input bit v, input logic [4:0] s, input bit r, input bit c);
        wave_vld = v; wave_in = s; res_ready = r; clr = c;
        @(posedge clk);
        model_step(v, s, r, c);
        #1;
        compare();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(res_valid), 0);
        chk({tag, "_period"}, int'(res_period), 0);
        chk({tag, "_max"}, int'(res_max), 0);
        chk({tag, "_min"}, int'(res_min), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_tmo"}, int'(timeout), 0);
    endtask

    logic [4:0] sq_pat [8];
    logic [4:0] tri_pat[10];

    initial begin
        sq_pat  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd7, 5'd7};
        tri_pat = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Square pattern, always ready
        for (int k = 0; k < 40; k++) step(1, sq_pat[k % 8], 1, 0);

        // Triangle, continuous then with every other sample invalid
        for (int k = 0; k < 40; k++) step(1, tri_pat[k % 10], 1, 0);
        for (int k = 0; k < 60; k++) begin
            step(1, tri_pat[k % 10], 1, 0);
            step(0, 5'd31, 1, 0);
        end

        // Backpressure across two results, then drain and clear
        for (int k = 0; k < 24; k++) step(1, sq_pat[k % 8], 0, 0);
        step(0, 5'd0, 1, 0);
        step(0, 5'd0, 1, 0);
        step(0, 5'd0, 0, 1);
        step(0, 5'd0, 0, 0);

        // Counter saturation with no further crossing
        step(1, 5'd0, 1, 0);
        for (int k = 0; k < 262; k++) step(1, 5'd5, 1, 0);
        for (int k = 0; k < 24; k++) step(1, sq_pat[k % 8], 1, 0);

        // Full holder accepted in the same cycle a new result lands
        step(0, 5'd0, 0, 1);
        for (int k = 0; k < 48; k++) step(1, sq_pat[k % 8], (k % 8) == 4, 0);

        // Asynchronous reset mid-period, between clock edges
        step(1, 5'd0, 1, 0);
        step(1, 5'd7, 1, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_zero("async_rst");
        #2 rst = 1'b0;
        for (int k = 0; k < 20; k++) step(1, sq_pat[(k + 4) % 8], 1, 0);

        // Random stream
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_monitor.md
Name: wave_monitor

Overview:
- Downstream consumer of the 5-bit waveform sample stream produced by the signal generator.
- Measures each period of the incoming waveform by detecting rising crossings of a threshold.
- For each completed period, reports the period length in samples, the peak sample and the trough sample.
- Results leave through a single-entry valid/ready output register, for a display or logging stage.

Parameters:
- WAVE_W, 5, sample width.
- CNT_W, 8, period counter width; maximum reportable period is 2^CNT_W-1 samples.
- THRESH, 3, crossing threshold, WAVE_W bits, unsigned.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous soft clear: returns to IDLE, drops held result, clears overflow.
- wave_in  in  WAVE_W  sample, unsigned.
- wave_vld  in  1  wave_in is a valid sample this cycle; cycles with wave_vld=0 are ignored entirely.
- res_period  out  CNT_W  samples in the completed period.
- res_max  out  WAVE_W  largest sample in the period.
- res_min  out  WAVE_W  smallest sample in the period.
- res_valid  out  1  result held, waiting for acceptance.
- res_ready  in  1  consumer accepts when res_valid & res_ready.
- overflow  out  1  sticky: a result was dropped because the holder was full.
- timeout  out  1  one-cycle pulse: period counter saturated with no crossing.

Behaviour:
- Reset (rst=1, async): state=IDLE, prev=0, cnt=0, run_max=0, run_min=all ones, all res_* =0, res_valid=0, overflow=0, timeout=0.
- clr has priority over wave_vld and res_ready. It performs the reset actions above in one cycle, except that it is synchronous.
- Crossing: wave_vld=1 & prev<THRESH & wave_in>=THRESH, where prev is the last valid sample. Comparisons are unsigned.
- prev updates on every valid sample in every state.
- IDLE: first valid sample loads prev only -> ARM. No crossing can be detected from IDLE.
- ARM: on a crossing, cnt=1, run_max=run_min=wave_in -> MEASURE. Non-crossing samples change only prev.
- MEASURE, non-crossing valid sample:
  - cnt+=1; run_max=max(run_max,wave_in); run_min=min(run_min,wave_in).
  - If cnt==2^CNT_W-1 before the increment: no increment; timeout=1 for one cycle; -> ARM; no result produced.
- MEASURE, crossing sample:
  - Emit {cnt, run_max, run_min} as the result. The crossing sample is not part of the finished period.
  - Restart with cnt=1, run_max=run_min=wave_in. Stay in MEASURE.
- Period definition: number of valid samples from one crossing sample, inclusive, to the next crossing sample, exclusive.
- Result latency: res_valid rises on the clock edge that samples the ending crossing. Outputs are registered; there is no combinational path from inputs to outputs.
- Output holder:
  - res_valid & res_ready in a cycle with no new result: res_valid->0.
  - New result while holder empty, or while holder full and res_ready=1 in the same cycle: load the new result, res_valid=1, no overflow.
  - New result while res_valid=1 & res_ready=0: the new result is dropped, the held result is unchanged, overflow->1 (sticky until rst/clr).
  - res_* remain stable while res_valid=1 & res_ready=0.
- res_ready while res_valid=0 has no effect.
- wave_vld=0 freezes cnt, run_max, run_min, prev and state; the holder handshake still operates.
- Reset mid-period discards the partial measurement with no result.

Decomposition:
- Shared package wave_pkg holds:
  - WAVE_W default;
  - state encoding for IDLE/ARM/MEASURE (2 bits);
  - the wave_choise code constants (SQUARE=0, SAW=1, TRI=2, CLK=3), shared with the generator.
- One natural sub-module: wave_result_holder, the single-entry valid/ready register with drop/overflow logic.
- Crossing detection, counter and min/max tracking stay in the top level.

Test Plan:
- Reset, then drive wave_vld=1 with a repeating pattern 0,0,0,0,7,7,7,7 (THRESH=3), res_ready=1 -> first result after the 2nd crossing: period=8, max=7, min=0; one result every 8 samples thereafter.
- Triangle 0,1,2,3,4,5,4,3,2,1 repeating -> period=10, max=5, min=0 each result. Then deassert wave_vld every other cycle -> same values, results spaced 20 cycles.
- Hold res_ready=0 across two results -> first result held stable, second dropped, overflow=1. Raise res_ready -> res_valid falls after one cycle. clr -> overflow=0.
- Constant wave_in=5 after ARM (one crossing, then no further crossings) -> after 255 counted samples, timeout pulses for exactly 1 cycle, state ARM, no result. A following crossing restarts cleanly.
- res_ready=1 in the same cycle a new result arrives while full -> new result loaded, overflow stays 0.
- Assert rst asynchronously mid-period, between clock edges -> all outputs 0 immediately. After release, IDLE requires 1 sample plus 2 crossings before the first result.
